// File: rtl/fe_uop_cache_dm.sv
// fe_uop_cache_dm
// Front-end micro-op cache, direct mapped, with a 2-entry pass-through FIFO.
// Every decoded uop goes through the FIFO to the backend. When the cache is
// enabled, the uop is also written into the direct-mapped array at the index
// taken from its PC. Fetch lookups return a registered hit and payload one
// cycle after the request.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   en                    cache enable (0: no fills, no hits, no counting)
//   inv                   single-cycle invalidate of every entry
//   stat_clr              clear hit_cnt and miss_cnt
//   in_valid/in_ready     decoded-uop handshake (in_pc, in_uop)
//   out_valid/out_ready   backend handshake (out_uop = oldest FIFO entry)
//   lk_valid, lk_pc       lookup request, no backpressure
//   lk_rsp_valid, lk_hit, lk_uop   lookup response, one cycle later
//   hit_cnt, miss_cnt     saturating 16-bit lookup statistics
module fe_uop_cache_dm #(
    parameter int UOP_W = 64,
    parameter int PC_W  = 32,
    parameter int SETS  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             inv,
    input  logic             stat_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [UOP_W-1:0] in_uop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [UOP_W-1:0] out_uop,
    input  logic             lk_valid,
    input  logic [PC_W-1:0]  lk_pc,
    output logic             lk_rsp_valid,
    output logic             lk_hit,
    output logic [UOP_W-1:0] lk_uop,
    output logic [15:0]      hit_cnt,
    output logic [15:0]      miss_cnt
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = PC_W - IDX_W;

    // FIFO state
    logic [UOP_W-1:0] fifo_q [2];
    logic [UOP_W-1:0] fifo_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    // Low during reset and high from the first edge after release, so that
    // in_ready stays low while rst is held.
    logic             ready_q, ready_d;

    // Cache array
    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [SETS];
    logic [TAG_W-1:0] tag_d [SETS];
    logic [UOP_W-1:0] uop_q [SETS];
    logic [UOP_W-1:0] uop_d [SETS];

    // Lookup response and statistics
    logic             lk_rsp_valid_q, lk_rsp_valid_d;
    logic             lk_hit_q, lk_hit_d;
    logic [UOP_W-1:0] lk_uop_q, lk_uop_d;
    logic [15:0]      hit_cnt_q, hit_cnt_d;
    logic [15:0]      miss_cnt_q, miss_cnt_d;

    logic             push_s, pop_s, fill_s, lk_match_s;
    logic [IDX_W-1:0] fill_idx_s, lk_idx_s;
    logic [TAG_W-1:0] fill_tag_s, lk_tag_s;

    assign in_ready     = ready_q & (count_q != 2'd2);
    assign out_valid    = (count_q != 2'd0);
    assign out_uop      = fifo_q[rd_ptr_q];
    assign lk_rsp_valid = lk_rsp_valid_q;
    assign lk_hit       = lk_hit_q;
    assign lk_uop       = lk_uop_q;
    assign hit_cnt      = hit_cnt_q;
    assign miss_cnt     = miss_cnt_q;

    assign push_s     = in_valid & in_ready;
    assign pop_s      = out_valid & out_ready;
    assign fill_s     = push_s & en & ~inv;
    assign fill_idx_s = in_pc[IDX_W-1:0];
    assign fill_tag_s = in_pc[PC_W-1:IDX_W];
    assign lk_idx_s   = lk_pc[IDX_W-1:0];
    assign lk_tag_s   = lk_pc[PC_W-1:IDX_W];
    // The match reads the pre-edge array, so a same-cycle fill is not seen.
    assign lk_match_s = en & ~inv & valid_q[lk_idx_s] & (tag_q[lk_idx_s] == lk_tag_s);

    // FIFO next-state: pointers, occupancy and storage
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ready_d  = 1'b1;
        if (push_s) begin
            fifo_d[wr_ptr_q] = in_uop;
            wr_ptr_d         = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Cache array next-state: invalidate beats fill
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        uop_d   = uop_q;
        if (inv) begin
            valid_d = '0;
        end else if (fill_s) begin
            valid_d[fill_idx_s] = 1'b1;
            tag_d[fill_idx_s]   = fill_tag_s;
            uop_d[fill_idx_s]   = in_uop;
        end else begin
            valid_d = valid_q;
        end
    end

    // Lookup response and saturating counters; stat_clr beats increments
    always_comb begin
        lk_rsp_valid_d = lk_valid;
        lk_hit_d       = lk_valid & lk_match_s;
        lk_uop_d       = lk_hit_d ? uop_q[lk_idx_s] : '0;
        hit_cnt_d      = hit_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        if (stat_clr) begin
            hit_cnt_d  = 16'd0;
            miss_cnt_d = 16'd0;
        end else if (lk_valid & en) begin
            if (lk_match_s) begin
                hit_cnt_d = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
            end else begin
                miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
            end
        end else begin
            hit_cnt_d  = hit_cnt_q;
            miss_cnt_d = miss_cnt_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b0;
            valid_q  <= '0;
            for (int i = 0; i < SETS; i++) begin
                tag_q[i] <= '0;
                uop_q[i] <= '0;
            end
            lk_rsp_valid_q <= 1'b0;
            lk_hit_q       <= 1'b0;
            lk_uop_q       <= '0;
            hit_cnt_q      <= 16'd0;
            miss_cnt_q     <= 16'd0;
        end else begin
            fifo_q         <= fifo_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            ready_q        <= ready_d;
            valid_q        <= valid_d;
            tag_q          <= tag_d;
            uop_q          <= uop_d;
            lk_rsp_valid_q <= lk_rsp_valid_d;
            lk_hit_q       <= lk_hit_d;
            lk_uop_q       <= lk_uop_d;
            hit_cnt_q      <= hit_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
        end
    end

endmodule

// File: tb/tb_fe_uop_cache_dm.sv
// Testbench for fe_uop_cache_dm. A behavioural model (queue FIFO, indexed
// arrays for the cache, integer counters) is compared against the DUT on
// every falling edge. Directed sequences add literal expectations.
module tb_fe_uop_cache_dm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, inv = 1'b0, stat_clr = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_pc = 32'd0;
    logic [63:0] in_uop = 64'd0;
    logic        out_valid, out_ready = 1'b0;
    logic [63:0] out_uop;
    logic        lk_valid = 1'b0;
    logic [31:0] lk_pc = 32'd0;
    logic        lk_rsp_valid, lk_hit;
    logic [63:0] lk_uop;
    logic [15:0] hit_cnt, miss_cnt;

    int n_checks = 0;
    int n_errors = 0;

    fe_uop_cache_dm #(.UOP_W(64), .PC_W(32), .SETS(16)) dut (
        .clk(clk), .rst(rst), .en(en), .inv(inv), .stat_clr(stat_clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_uop(in_uop),
        .out_valid(out_valid), .out_ready(out_ready), .out_uop(out_uop),
        .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_rsp_valid(lk_rsp_valid),
        .lk_hit(lk_hit), .lk_uop(lk_uop), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_q[$];
    bit          m_ready = 1'b0;
    bit          m_valid [16];
    logic [31:0] m_tag [16];
    logic [63:0] m_uop [16];
    bit          m_rsp = 1'b0, m_hit = 1'b0;
    logic [63:0] m_lk_uop = 64'd0;
    int          m_hits = 0, m_misses = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_ready = 1'b0;
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_rsp = 1'b0; m_hit = 1'b0; m_lk_uop = 64'd0;
            m_hits = 0; m_misses = 0;
        end else begin
            bit push, pop, hit;
            int li, fi;
            push = in_valid && m_ready && (m_q.size() < 2);
            pop  = (m_q.size() > 0) && out_ready;
            li   = int'(lk_pc % 32'd16);
            hit  = en && !inv && m_valid[li] && (m_tag[li] == lk_pc / 32'd16);
            m_rsp    = lk_valid;
            m_hit    = lk_valid && hit;
            m_lk_uop = m_hit ? m_uop[li] : 64'd0;
            if (stat_clr) begin
                m_hits = 0; m_misses = 0;
            end else if (lk_valid && en) begin
                if (hit) m_hits = (m_hits < 65535) ? m_hits + 1 : 65535;
                else     m_misses = (m_misses < 65535) ? m_misses + 1 : 65535;
            end
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(in_uop);
            fi = int'(in_pc % 32'd16);
            if (inv) begin
                foreach (m_valid[i]) m_valid[i] = 1'b0;
            end else if (push && en) begin
                m_valid[fi] = 1'b1;
                m_tag[fi]   = in_pc / 32'd16;
                m_uop[fi]   = in_uop;
            end
            m_ready = 1'b1;
        end
    end

    // Compare DUT against model each cycle
    always @(negedge clk) begin
        chk("in_ready", {63'd0, in_ready}, {63'd0, m_ready && (m_q.size() < 2)});
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_q.size() > 0});
        if (m_q.size() > 0) chk("out_uop", out_uop, m_q[0]);
        chk("lk_rsp_valid", {63'd0, lk_rsp_valid}, {63'd0, m_rsp});
        chk("lk_hit", {63'd0, lk_hit}, {63'd0, m_hit});
        chk("lk_uop", lk_uop, m_lk_uop);
        chk("hit_cnt", {48'd0, hit_cnt}, 64'(m_hits));
        chk("miss_cnt", {48'd0, miss_cnt}, 64'(m_misses));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        lk_valid = 1'b1; lk_pc = pc;
        tick();
        lk_valid = 1'b0;
    endtask

    task automatic fill(input logic [31:0] pc, input logic [63:0] u);
        in_valid = 1'b1; in_pc = pc; in_uop = u;
        tick();
        in_valid = 1'b0;
    endtask

    logic [63:0] got[$];

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_lk_hit", {63'd0, lk_hit}, 64'd0);
        chk("rst_hit_cnt", {48'd0, hit_cnt}, 64'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", {63'd0, in_ready}, 64'd1);

        // Pass-through with cache disabled
        en = 1'b0; out_ready = 1'b0;
        lk_valid = 1'b1; lk_pc = 32'h10;
        in_valid = 1'b1; in_pc = 32'h10; in_uop = 64'hA1; tick();
        in_uop = 64'hA2; tick();
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        in_uop = 64'hA3; tick();
        chk("full_hold_in_ready", {63'd0, in_ready}, 64'd0);
        chk("pt_lk_hit", {63'd0, lk_hit}, 64'd0);
        lk_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bit took_a3;
            took_a3 = in_valid && in_ready;
            if (out_valid) got.push_back(out_uop);
            tick();
            if (took_a3) in_valid = 1'b0;
        end
        chk("pt_count", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("pt_0", got[0], 64'hA1);
            chk("pt_1", got[1], 64'hA2);
            chk("pt_2", got[2], 64'hA3);
        end

        // Fill then hit
        en = 1'b1;
        fill(32'h1004, 64'h55);
        lookup(32'h1004);
        chk("hit_rsp_valid", {63'd0, lk_rsp_valid}, 64'd1);
        chk("hit_hit", {63'd0, lk_hit}, 64'd1);
        chk("hit_uop", lk_uop, 64'h55);
        chk("hit_cnt1", {48'd0, hit_cnt}, 64'd1);

        // Aliasing on the same index
        lookup(32'h2004);
        chk("alias_miss", {63'd0, lk_hit}, 64'd0);
        chk("alias_miss_cnt", {48'd0, miss_cnt}, 64'd1);
        fill(32'h2004, 64'h66);
        lookup(32'h1004);
        chk("alias_old_miss", {63'd0, lk_hit}, 64'd0);
        lookup(32'h2004);
        chk("alias_new_hit", {63'd0, lk_hit}, 64'd1);
        chk("alias_new_uop", lk_uop, 64'h66);

        // Collisions
        inv = 1'b1; tick(); inv = 1'b0;
        in_valid = 1'b1; in_pc = 32'h30; in_uop = 64'h77;
        lk_valid = 1'b1; lk_pc = 32'h30;
        tick();
        in_valid = 1'b0; lk_valid = 1'b0;
        chk("rbw_miss", {63'd0, lk_hit}, 64'd0);
        lookup(32'h30);
        chk("rbw_next_hit", {63'd0, lk_hit}, 64'd1);
        chk("rbw_next_uop", lk_uop, 64'h77);
        inv = 1'b1; in_valid = 1'b1; in_pc = 32'h30; in_uop = 64'h88;
        tick();
        inv = 1'b0; in_valid = 1'b0;
        lookup(32'h30);
        chk("inv_wins_miss", {63'd0, lk_hit}, 64'd0);
        chk("coll_hit_cnt", {48'd0, hit_cnt}, 64'd3);
        chk("coll_miss_cnt", {48'd0, miss_cnt}, 64'd4);

        // Saturation
        lk_valid = 1'b1; lk_pc = 32'h500;
        repeat (70000) tick();
        chk("sat_miss", {48'd0, miss_cnt}, 64'hFFFF);
        chk("sat_hit", {48'd0, hit_cnt}, 64'd3);
        stat_clr = 1'b1; tick(); stat_clr = 1'b0; lk_valid = 1'b0;
        chk("clr_miss", {48'd0, miss_cnt}, 64'd0);
        chk("clr_hit", {48'd0, hit_cnt}, 64'd0);

        // Asynchronous reset mid-cycle
        out_ready = 1'b0;
        fill(32'h40, 64'h99);
        fill(32'h41, 64'h9A);
        chk("pre_rst_out_valid", {63'd0, out_valid}, 64'd1);
        #2 rst = 1'b1;
        #1 chk("async_out_valid", {63'd0, out_valid}, 64'd0);
        chk("async_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        lookup(32'h40);
        chk("post_rst_miss40", {63'd0, lk_hit}, 64'd0);
        lookup(32'h41);
        chk("post_rst_miss41", {63'd0, lk_hit}, 64'd0);
        chk("post_rst_miss_cnt", {48'd0, miss_cnt}, 64'd2);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
